// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (core, DMA) and the BRAM.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              c_req;
  logic [3:0]        c_wea;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic              core_stall;
  logic              d_req;
  logic              d_lock;
  logic [3:0]        d_wea;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic              mem_en;
  logic [3:0]        mem_wea;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [31:0]       rdata;

  modport slave (
    input  c_req, c_wea, c_addr, c_wdata,
    input  d_req, d_lock, d_wea, d_addr, d_wdata,
    input  mem_rdata,
    output c_gnt, c_rvalid, core_stall,
    output d_gnt, d_rvalid,
    output mem_en, mem_wea, mem_addr, mem_wdata, rdata
  );

  modport master (
    output c_req, c_wea, c_addr, c_wdata,
    output d_req, d_lock, d_wea, d_addr, d_wdata,
    output mem_rdata,
    input  c_gnt, c_rvalid, core_stall,
    input  d_gnt, d_rvalid,
    input  mem_en, mem_wea, mem_addr, mem_wdata, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data BRAM arbiter: core has priority, DMA is protected by a
// starvation counter and may hold a bounded locked burst.
module dmem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 16
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    FREE  = 1'b0,
    DLOCK = 1'b1
  } st_t;

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

  st_t        st;
  logic [7:0] wait_cnt;
  logic [7:0] burst_cnt;
  logic       rv_c;
  logic       rv_d;
  logic       starve;
  logic       lock_ok;
  logic       d_sel;
  logic       c_sel;

  assign starve  = (wait_cnt >= MAX_WAIT_C);
  assign lock_ok = (st == DLOCK) && bus.d_lock && (burst_cnt < BURST_MAX_C);
  assign d_sel   = bus.d_req && (!bus.c_req || starve || lock_ok);
  assign c_sel   = bus.c_req && !d_sel;

  assign bus.d_gnt      = d_sel;
  assign bus.c_gnt      = c_sel;
  assign bus.core_stall = bus.c_req && !c_sel;
  assign bus.mem_en     = c_sel | d_sel;
  assign bus.c_rvalid   = rv_c;
  assign bus.d_rvalid   = rv_d;
  assign bus.rdata      = bus.mem_rdata;

  // BRAM command mux; idle bus is driven to all zeros
  always_comb begin
    bus.mem_wea   = 4'b0000;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = 32'h0000_0000;
    if (d_sel) begin
      bus.mem_wea   = bus.d_wea;
      bus.mem_addr  = bus.d_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.d_wdata;
    end else if (c_sel) begin
      bus.mem_wea   = bus.c_wea;
      bus.mem_addr  = bus.c_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.c_wdata;
    end else begin
      bus.mem_wea   = 4'b0000;
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = 32'h0000_0000;
    end
  end

  // DMA starvation counter: counts consecutive denied cycles of a pending request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (d_sel || !bus.d_req) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Burst-lock FSM; once the beat budget is spent a core request forces release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= FREE;
      burst_cnt <= 8'd0;
    end else begin
      case (st)
        FREE: begin
          if (d_sel && bus.d_lock) begin
            st        <= DLOCK;
            burst_cnt <= 8'd1;
          end else begin
            st        <= FREE;
            burst_cnt <= 8'd0;
          end
        end
        DLOCK: begin
          if (!bus.d_lock || !bus.d_req || ((burst_cnt >= BURST_MAX_C) && bus.c_req)) begin
            st        <= FREE;
            burst_cnt <= 8'd0;
          end else if (d_sel && (burst_cnt != 8'hFF)) begin
            st        <= DLOCK;
            burst_cnt <= burst_cnt + 8'd1;
          end else begin
            st        <= DLOCK;
            burst_cnt <= burst_cnt;
          end
        end
        default: begin
          st        <= FREE;
          burst_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Read-return flags: BRAM data lands one cycle after a granted read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv_c <= 1'b0;
      rv_d <= 1'b0;
    end else begin
      rv_c <= c_sel && (bus.c_wea == 4'b0000);
      rv_d <= d_sel && (bus.d_wea == 4'b0000);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level reference model and a BRAM model.
module tb_dmem_arbiter;

  localparam int ADDR_W    = 14;
  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 16;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (MAX_WAIT),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model driven by the DUT's memory port (read-first, 1-cycle latency)
  logic [31:0] bram [0:63];
  logic [31:0] mem_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      mem_rdata_q <= bram[bus.mem_addr[5:0]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wea[b]) bram[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] mdl [0:63];
  int          m_waited;
  int          m_beats;
  bit          m_locked;
  bit          e_rvc;
  bit          e_rvd;
  logic [31:0] e_rdata;

  function automatic bit model_dwins();
    return bus.d_req && (!bus.c_req || (m_waited >= MAX_WAIT) ||
                         (m_locked && bus.d_lock && (m_beats < BURST_MAX)));
  endfunction

  task automatic model_reset();
    m_waited = 0;
    m_beats  = 0;
    m_locked = 0;
    e_rvc    = 0;
    e_rvd    = 0;
  endtask

  task automatic mem_access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    int idx;
    idx = int'(a[7:2]);
    if (w == 4'b0000) e_rdata = mdl[idx];
    for (int b = 0; b < 4; b++)
      if (w[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_advance();
    bit dw;
    bit cw;
    dw = model_dwins();
    cw = bus.c_req && !dw;
    e_rvc = cw && (bus.c_wea == 4'b0000);
    e_rvd = dw && (bus.d_wea == 4'b0000);
    if (cw) mem_access(bus.c_addr, bus.c_wea, bus.c_wdata);
    else if (dw) mem_access(bus.d_addr, bus.d_wea, bus.d_wdata);
    if (dw || !bus.d_req) m_waited = 0;
    else if (m_waited < 255) m_waited = m_waited + 1;
    if (!m_locked) begin
      if (dw && bus.d_lock) begin
        m_locked = 1;
        m_beats  = 1;
      end
    end else if (!bus.d_lock || !bus.d_req || ((m_beats >= BURST_MAX) && bus.c_req)) begin
      m_locked = 0;
      m_beats  = 0;
    end else if (dw && (m_beats < 255)) begin
      m_beats = m_beats + 1;
    end
  endtask

  task automatic tick();
    if (reset) model_advance();
    else model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.c_req  = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_lock = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.c_req = 1'b1; bus.c_wea = 4'b0000; bus.c_addr = 32'h0; bus.c_wdata = 32'h0;
    bus.d_req = 1'b1; bus.d_lock = 1'b0; bus.d_wea = 4'b0000; bus.d_addr = 32'h4; bus.d_wdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if (bus.c_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0)
        $display("FAIL reset_rvalid got c=%b d=%b want 0 0", bus.c_rvalid, bus.d_rvalid);
      else pass_cnt++;
      tick();
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0)
      $display("FAIL reset_release_gnt got c=%b d=%b want 1 0", bus.c_gnt, bus.d_gnt);
    else pass_cnt++;
    tick();
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.c_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0)
      $display("FAIL reset_first_read got c=%b d=%b want 1 0", bus.c_rvalid, bus.d_rvalid);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_core_only();
    bus.c_req = 1'b1; bus.c_wea = 4'b0000; bus.c_addr = 32'h0000_0010;
    @(negedge clk);
    total_cnt++;
    if (bus.mem_addr !== 14'd4 || bus.mem_en !== 1'b1 || bus.mem_wea !== 4'b0000 ||
        bus.core_stall !== 1'b0 || bus.c_gnt !== 1'b1)
      $display("FAIL core_cmd got addr=%0d en=%b wea=%b stall=%b gnt=%b want 4 1 0000 0 1",
               bus.mem_addr, bus.mem_en, bus.mem_wea, bus.core_stall, bus.c_gnt);
    else pass_cnt++;
    tick();
    bus.c_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.c_rvalid !== 1'b1 || bus.rdata !== 32'hC0DE_0004)
      $display("FAIL core_rdata got rv=%b data=%h want 1 c0de0004", bus.c_rvalid, bus.rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_starvation();
    bus.c_req = 1'b1; bus.c_wea = 4'b0000; bus.c_addr = 32'h0000_0020;
    bus.d_req = 1'b1; bus.d_lock = 1'b0; bus.d_wea = 4'b0000; bus.d_addr = 32'h0000_0030;
    for (int k = 1; k <= 18; k++) begin
      bit want_d;
      want_d = (k == 9) || (k == 18);
      @(negedge clk);
      total_cnt++;
      if (bus.d_gnt !== want_d || bus.c_gnt !== !want_d || bus.core_stall !== want_d)
        $display("FAIL starve_cycle%0d got d=%b c=%b stall=%b want %b %b %b",
                 k, bus.d_gnt, bus.c_gnt, bus.core_stall, want_d, !want_d, want_d);
      else pass_cnt++;
      tick();
    end
    idle();
  endtask

  task automatic test_burst_lock();
    bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_wea = 4'b0000; bus.d_addr = 32'h0000_0008;
    bus.c_wea = 4'b0000; bus.c_addr = 32'h0000_000C;
    for (int k = 1; k <= 17; k++) begin
      bus.c_req = (k >= 2);
      @(negedge clk);
      total_cnt++;
      if (bus.d_gnt !== (k <= 16) || bus.c_gnt !== (k == 17) ||
          bus.d_rvalid !== (k >= 2) || bus.c_rvalid !== 1'b0)
        $display("FAIL burst_beat%0d got d=%b c=%b drv=%b crv=%b want %b %b %b 0",
                 k, bus.d_gnt, bus.c_gnt, bus.d_rvalid, bus.c_rvalid, (k <= 16), (k == 17), (k >= 2));
      else pass_cnt++;
      tick();
    end
    idle();
  endtask

  task automatic test_write_read();
    bus.d_req = 1'b1; bus.d_lock = 1'b0; bus.d_wea = 4'b0011;
    bus.d_addr = 32'h0000_0040; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total_cnt++;
    if (bus.d_gnt !== 1'b1 || bus.mem_wea !== 4'b0011 || bus.mem_addr !== 14'd16 ||
        bus.mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL dma_write got gnt=%b wea=%b addr=%0d data=%h want 1 0011 16 deadbeef",
               bus.d_gnt, bus.mem_wea, bus.mem_addr, bus.mem_wdata);
    else pass_cnt++;
    tick();
    bus.d_req = 1'b0; bus.d_wea = 4'b0000;
    bus.c_req = 1'b1; bus.c_wea = 4'b0000; bus.c_addr = 32'h0000_0040;
    @(negedge clk);
    total_cnt++;
    if (bus.d_rvalid !== 1'b0 || bus.c_gnt !== 1'b1)
      $display("FAIL write_no_rvalid got drv=%b cgnt=%b want 0 1", bus.d_rvalid, bus.c_gnt);
    else pass_cnt++;
    tick();
    bus.c_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.c_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.rdata !== 32'hC0DE_BEEF)
      $display("FAIL readback got crv=%b drv=%b data=%h want 1 0 c0debeef",
               bus.c_rvalid, bus.d_rvalid, bus.rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_async_reset();
    bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_wea = 4'b0000; bus.d_addr = 32'h0000_0014;
    bus.c_req = 1'b0; bus.c_wea = 4'b0000; bus.c_addr = 32'h0000_0018;
    for (int k = 0; k < 5; k++) tick();
    #2;
    reset = 1'b0;
    bus.c_req = 1'b1;
    #1;
    model_reset();
    total_cnt++;
    if (bus.d_rvalid !== 1'b0 || bus.c_rvalid !== 1'b0 || bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0)
      $display("FAIL async_reset got drv=%b crv=%b c=%b d=%b want 0 0 1 0",
               bus.d_rvalid, bus.c_rvalid, bus.c_gnt, bus.d_gnt);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0)
      $display("FAIL async_release got c=%b d=%b want 1 0", bus.c_gnt, bus.d_gnt);
    else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit          dw;
      bit          cw;
      logic [31:0] sa;
      logic [3:0]  sw;
      logic [31:0] sd;
      bus.c_req   = ($urandom_range(0, 3) != 0);
      bus.c_wea   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      bus.c_addr  = {24'h0, 6'($urandom), 2'($urandom)};
      bus.c_wdata = $urandom;
      bus.d_req   = ($urandom_range(0, 3) != 0);
      bus.d_lock  = ($urandom_range(0, 7) != 0);
      bus.d_wea   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      bus.d_addr  = {24'h0, 6'($urandom), 2'($urandom)};
      bus.d_wdata = $urandom;
      dw = model_dwins();
      cw = bus.c_req && !dw;
      sa = dw ? bus.d_addr : (cw ? bus.c_addr : 32'h0);
      sw = dw ? bus.d_wea : (cw ? bus.c_wea : 4'b0000);
      sd = dw ? bus.d_wdata : (cw ? bus.c_wdata : 32'h0);
      @(negedge clk);
      total_cnt++;
      if (bus.d_gnt !== dw || bus.c_gnt !== cw || bus.core_stall !== (bus.c_req && !cw) ||
          bus.mem_en !== (dw || cw))
        $display("FAIL rand_gnt%0d got d=%b c=%b stall=%b en=%b want %b %b %b %b",
                 n, bus.d_gnt, bus.c_gnt, bus.core_stall, bus.mem_en, dw, cw, bus.c_req && !cw, dw || cw);
      else pass_cnt++;
      total_cnt++;
      if (bus.mem_addr !== sa[15:2] || bus.mem_wea !== sw || bus.mem_wdata !== sd)
        $display("FAIL rand_mux%0d got addr=%h wea=%b data=%h want %h %b %h",
                 n, bus.mem_addr, bus.mem_wea, bus.mem_wdata, sa[15:2], sw, sd);
      else pass_cnt++;
      total_cnt++;
      if (bus.c_rvalid !== e_rvc || bus.d_rvalid !== e_rvd ||
          ((e_rvc || e_rvd) && bus.rdata !== e_rdata))
        $display("FAIL rand_rd%0d got crv=%b drv=%b data=%h want %b %b %h",
                 n, bus.c_rvalid, bus.d_rvalid, bus.rdata, e_rvc, e_rvd, e_rdata);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    mem_rdata_q = 32'h0;
    for (int i = 0; i < 64; i++) begin
      bram[i] = 32'hC0DE_0000 + 32'(i);
      mdl[i]  = 32'hC0DE_0000 + 32'(i);
    end
    e_rdata = 32'h0;
    model_reset();
    test_reset();
    test_core_only();
    test_starvation();
    test_burst_lock();
    test_write_read();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
